// File: rtl/add_tree_acc.sv
// add_tree_acc: sums NUM lanes per beat with a registered binary adder tree,
// then accumulates the tree outputs over a group closed by in_last.
// Signed/unsigned mode is chosen on the first beat of a group and rides
// down the pipeline with every beat.

// One tree node: registered sum of two operands, widened by one bit per mode.
module add_tree_node #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         mode,
   output logic [W:0]   sum
);
   logic [W:0] ea, eb;

   // extend both operands by one bit (sign or zero) so the add is exact
   always_comb begin
      ea = mode ? {a[W-1], a} : {1'b0, a};
      eb = mode ? {b[W-1], b} : {1'b0, b};
   end

   // data registers carry no reset; the stage valid bit qualifies them
   always_ff @(posedge clk) begin
      sum <= ea + eb;
   end
endmodule

module add_tree_acc #(
   parameter int WIDTH = 5,
   parameter int NUM   = 8,
   parameter int ACC_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_last,
   input  logic                   sus,
   input  logic [NUM*WIDTH-1:0]   in_data,
   output logic                   out_valid,
   output logic [ACC_W-1:0]       out_data,
   output logic                   out_ovf,
   output logic                   busy
);
   localparam int LOG = $clog2(NUM);
   localparam int TW  = WIDTH + LOG;

   if (NUM < 2 || (1 << LOG) != NUM) begin : g_num_chk
      $error("add_tree_acc: NUM must be a power of two >= 2");
   end
   if (ACC_W < TW) begin : g_accw_chk
      $error("add_tree_acc: ACC_W must be at least WIDTH+clog2(NUM)");
   end

   // ---------------- input side: group mode ----------------
   logic in_first, grp_sus, eff_mode;

   assign eff_mode = in_first ? sus : grp_sus;

   // latch the mode on a group's first beat; reopen after each accepted last
   always_ff @(posedge clk) begin
      if (rst) begin
         in_first <= 1'b1;
         grp_sus  <= 1'b0;
      end else if (in_valid) begin
         if (in_first) grp_sus <= sus;
         in_first <= in_last;
      end
   end

   // ---------------- adder tree ----------------
   wire [LOG:1] stage_vld;

   for (genvar k = 1; k <= LOG; k++) begin : lvl
      localparam int W = WIDTH + k - 1;   // operand width into this level
      localparam int N = NUM >> k;        // nodes in this level

      logic [2*N-1:0][W-1:0] src;
      logic [N-1:0][W:0]     sum;
      logic                  v_in, l_in, m_in;
      logic                  vld, last, mode;

      if (k == 1) begin : g_src
         assign src  = in_data;
         assign v_in = in_valid;
         assign l_in = in_valid & in_last;
         assign m_in = eff_mode;
      end else begin : g_src
         assign src  = lvl[k-1].sum;
         assign v_in = lvl[k-1].vld;
         assign l_in = lvl[k-1].last;
         assign m_in = lvl[k-1].mode;
      end

      for (genvar i = 0; i < N; i++) begin : node
         add_tree_node #(.W(W)) u_node (
            .clk  (clk),
            .a    (src[2*i]),
            .b    (src[2*i+1]),
            .mode (m_in),
            .sum  (sum[i])
         );
      end

      // valid/last/mode follow the data through this level
      always_ff @(posedge clk) begin
         if (rst) begin
            vld  <= 1'b0;
            last <= 1'b0;
            mode <= 1'b0;
         end else begin
            vld  <= v_in;
            last <= l_in;
            mode <= m_in;
         end
      end

      assign stage_vld[k] = vld;
   end

   // ---------------- accumulator ----------------
   logic [TW-1:0]    tsum;
   logic             tv, tl, tm;
   logic [ACC_W-1:0] acc, ext, base;
   logic [ACC_W:0]   full;
   logic             acc_first, ovf, ovf_now, ovf_next;

   assign tsum = lvl[LOG].sum[0];
   assign tv   = lvl[LOG].vld;
   assign tl   = lvl[LOG].last;
   assign tm   = lvl[LOG].mode;

   // extend the tree sum, add it to the running total and detect overflow
   always_comb begin
      ext      = tm ? ACC_W'($signed(tsum)) : ACC_W'(tsum);
      base     = acc_first ? '0 : acc;
      full     = {1'b0, base} + {1'b0, ext};
      ovf_now  = tm ? ((base[ACC_W-1] == ext[ACC_W-1]) && (full[ACC_W-1] != ext[ACC_W-1]))
                    : full[ACC_W];
      ovf_next = (acc_first ? 1'b0 : ovf) | ovf_now;
   end

   // accumulate each valid tree output; emit one result per closed group
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         ovf       <= 1'b0;
         acc_first <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else begin
         out_valid <= tv & tl;
         if (tv) begin
            acc       <= full[ACC_W-1:0];
            ovf       <= ovf_next;
            acc_first <= tl;
            if (tl) begin
               out_data <= full[ACC_W-1:0];
               out_ovf  <= ovf_next;
            end
         end
      end
   end

   assign busy = (|stage_vld) | ~in_first | ~acc_first;
endmodule

// File: doc/add_tree_acc.md
Name: add_tree_acc

Overview:
- Pipelined, parametrised multi-operand adder with signed/unsigned mode select (`sus`) and a group accumulator.
- Each beat sums NUM lanes of WIDTH bits through a registered binary adder tree.
- Tree results are accumulated across a group of beats closed by `in_last`, and one result per group is emitted.
- Serves as the column-sum / partial-sum reduction stage behind the digital CIM array.

Parameters:
- WIDTH, 5, lane operand width in bits.
- NUM, 8, number of lanes; power of two, at least 2. LOG = clog2(NUM).
- ACC_W, 16, accumulator and output width; must be at least WIDTH+LOG (elaboration error otherwise).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat present on in_data this cycle.
- in_last  in  1  qualified by in_valid; this beat closes the group.
- sus  in  1  1 = signed (two's complement), 0 = unsigned; sampled on the first beat of a group.
- in_data  in  NUM*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
- out_valid  out  1  one-cycle pulse; group result is on out_data.
- out_data  out  ACC_W  group sum, modulo 2^ACC_W.
- out_ovf  out  1  group sum not representable in ACC_W under the group's mode; valid with out_valid.
- busy  out  1  a tree stage holds valid data, or a group is open.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All pipeline valid bits, accumulator, group-open flags and the overflow flag clear.
  - out_valid=0, out_data=0, out_ovf=0, busy=0.
  - In-flight beats are discarded and never produce out_valid.
- No backpressure: a beat is accepted every cycle in_valid=1.
- Group mode:
  - Input-side first flag is set after reset and after each accepted in_last beat.
  - On a beat with first=1, sus is latched into grp_sus; the effective mode is sus for that beat and grp_sus for later beats.
  - Changes to sus mid-group are ignored.
  - The mode bit travels down the pipeline with each beat.
- Tree:
  - LOG registered stages; stage k adds adjacent pairs of stage k-1.
  - Each level widens by 1 bit: sign-extend when mode=1, zero-extend when mode=0.
  - Tree output is WIDTH+LOG bits and exact; the tree never overflows.
  - Valid, last and mode propagate with the data.
  - Tree latency: LOG cycles.
- Accumulator stage (one register stage after the tree):
  - On a valid tree output, the sum is extended to ACC_W per mode.
  - acc <= (acc_first ? 0 : acc) + ext_sum.
  - acc_first sets after reset and after each last beat.
- Overflow:
  - Checked per addition: signed mode flags when operand signs match and the result sign differs; unsigned mode flags on carry-out of ACC_W.
  - Sticky across the group and cleared at the first beat of the next group.
  - Result wraps modulo 2^ACC_W.
- Output:
  - When the last beat is accumulated, out_valid=1 on the next cycle with out_data = final acc and out_ovf = sticky flag.
  - Latency from the in_last beat at the input to out_valid: LOG+1 cycles.
  - out_data and out_ovf hold until the next out_valid.
- Back-to-back: single-beat groups on consecutive cycles give out_valid on consecutive cycles, with no bubbles and no cross-group leakage.
- Group of one beat: in_valid and in_last together give a valid group.
- busy=0 when idle with no open group. in_last without in_valid is ignored.

Test Plan:
- NUM=8, WIDTH=5, ACC_W=16, sus=0: one beat, all lanes 31, in_last=1 -> out_valid exactly 4 cycles later, out_data=248 (0x00F8), out_ovf=0.
- sus=1: one beat, all lanes 5'b10000 (-16) -> out_data=0xFF80 (-128), out_ovf=0. Same data with sus=0 -> 128 (0x0080).
- sus=1 on the first beat, then sus=0 on the following beats: 3 beats with lanes all -1, all 3, all 5 (last on the third) -> out_data=56 (0x0038), i.e. signed mode held for the group, out_ovf=0.
- ACC_W=8, sus=0: 2 beats of all lanes 31 -> out_data=240 (0xF0), out_ovf=1. Next group, 1 beat of all lanes 1 -> out_data=8, out_ovf=0.
- Four single-beat groups on consecutive cycles with lanes all 1, 2, 3, 4 (sus=0) -> four consecutive out_valid pulses carrying 8, 16, 24, 32.
- Two beats of all lanes 7 without last, then rst for 1 cycle -> no out_valid, busy=0 the cycle after reset. Then one beat of all lanes 2 with last -> out_data=16.
